// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter and its burst sequencer.
package dmem_arb_pkg;

    localparam int LINE_BYTES = 32;
    localparam int LINE_OFF_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        CPU_XFER,
        ACC_XFER
    } arb_state_t;

    typedef enum logic {
        REQ_CPU,
        REQ_ACC
    } req_id_t;

endpackage

// File: rtl/dmem_burst_seq.sv
// Beat counter and line-address incrementer for one accelerator burst.
module dmem_burst_seq
    import dmem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int LW         = 3,
    parameter int LINE_BYTES = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] base,
    input  logic [LW-1:0] len,
    output logic          beat,
    output logic [LW-1:0] idx,
    output logic [AW-1:0] addr,
    output logic          last
);

    logic [LW-1:0] len_q;

    assign last = beat && (idx == len_q);

    // A start on the final beat chains straight into the next burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat  <= 1'b0;
            idx   <= '0;
            addr  <= '0;
            len_q <= '0;
        end else if (start) begin
            beat  <= 1'b1;
            idx   <= '0;
            addr  <= base;
            len_q <= len;
        end else if (beat) begin
            if (last) begin
                beat <= 1'b0;
            end else begin
                idx  <= idx + LW'(1);
                addr <= addr + AW'(LINE_BYTES);
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the CPU word port and
// the accelerator line port; sequences bursts and counts CPU stall cycles.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int  AW         = 32,
    parameter int  MAX_BEATS  = 8,
    parameter int  LINE_BYTES = 32,
    parameter int  WAITW      = 16,
    localparam int LW         = $clog2(MAX_BEATS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_req,
    output logic             c_gnt,
    input  logic [AW-1:0]    c_addr,
    input  logic [31:0]      c_wdata,
    input  logic [3:0]       c_we,
    output logic [31:0]      c_rdata,
    output logic             c_rvalid,
    input  logic             a_req,
    output logic             a_gnt,
    input  logic [AW-1:0]    a_addr,
    input  logic [LW-1:0]    a_len,
    input  logic             a_we,
    input  logic [255:0]     a_wdata,
    output logic             a_beat,
    output logic [LW-1:0]    a_beat_idx,
    output logic [255:0]     a_rdata,
    output logic             a_rvalid,
    output logic [AW-1:0]    daddr,
    output logic [31:0]      dwdata,
    output logic [3:0]       dwe,
    input  logic [31:0]      drdata,
    output logic [255:0]     mm_dwdata,
    output logic             mm_dwe,
    input  logic [255:0]     mm_drdata,
    output logic [WAITW-1:0] cpu_wait_cnt
);

    arb_state_t    state;
    req_id_t       last_win;
    logic [AW-1:0] cpu_addr_q;
    logic [31:0]   cpu_wdata_q;
    logic [3:0]    cpu_we_q;
    logic          acc_we_q;
    logic [AW-1:0] hold_addr;
    logic          seq_beat;
    logic          seq_last;
    logic [LW-1:0] seq_idx;
    logic [AW-1:0] seq_addr;
    logic [AW-1:0] acc_base;
    logic          final_cycle;
    logic          can_grant;

    assign acc_base    = a_addr & ~(AW'(LINE_BYTES) - AW'(1));
    assign final_cycle = (state == CPU_XFER) || ((state == ACC_XFER) && seq_last);
    assign can_grant   = !reset && ((state == IDLE) || final_cycle);
    assign c_gnt       = can_grant && c_req && (!a_req || (last_win == REQ_ACC));
    assign a_gnt       = can_grant && a_req && (!c_req || (last_win == REQ_CPU));

    dmem_burst_seq #(
        .AW         (AW),
        .LW         (LW),
        .LINE_BYTES (LINE_BYTES)
    ) u_seq (
        .clk   (clk),
        .reset (reset),
        .start (a_gnt),
        .base  (acc_base),
        .len   (a_len),
        .beat  (seq_beat),
        .idx   (seq_idx),
        .addr  (seq_addr),
        .last  (seq_last)
    );

    // Write strobes are gated by reset so a reset cycle never commits a beat.
    assign daddr      = (state == ACC_XFER) ? seq_addr :
                        (state == CPU_XFER) ? cpu_addr_q : hold_addr;
    assign dwe        = ((state == CPU_XFER) && !reset) ? cpu_we_q : 4'h0;
    assign dwdata     = cpu_wdata_q;
    assign mm_dwe     = (state == ACC_XFER) && acc_we_q && !reset;
    assign mm_dwdata  = a_wdata;
    assign a_beat     = seq_beat;
    assign a_beat_idx = seq_idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_win     <= REQ_ACC;
            cpu_addr_q   <= '0;
            cpu_wdata_q  <= '0;
            cpu_we_q     <= '0;
            acc_we_q     <= 1'b0;
            hold_addr    <= '0;
            c_rdata      <= '0;
            c_rvalid     <= 1'b0;
            a_rdata      <= '0;
            a_rvalid     <= 1'b0;
            cpu_wait_cnt <= '0;
        end else begin
            hold_addr <= daddr;
            c_rvalid  <= (state == CPU_XFER) && (cpu_we_q == 4'h0);
            a_rvalid  <= (state == ACC_XFER) && !acc_we_q;
            if ((state == CPU_XFER) && (cpu_we_q == 4'h0)) begin
                c_rdata <= drdata;
            end
            if ((state == ACC_XFER) && !acc_we_q) begin
                a_rdata <= mm_drdata;
            end
            if (c_req && !c_gnt && (cpu_wait_cnt != '1)) begin
                cpu_wait_cnt <= cpu_wait_cnt + WAITW'(1);
            end
            if (c_gnt) begin
                state       <= CPU_XFER;
                last_win    <= REQ_CPU;
                cpu_addr_q  <= c_addr;
                cpu_wdata_q <= c_wdata;
                cpu_we_q    <= c_we;
            end else if (a_gnt) begin
                state    <= ACC_XFER;
                last_win <= REQ_ACC;
                acc_we_q <= a_we;
            end else if (final_cycle) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a transaction-level
// schedule model and a byte-array reference memory.
module tb_dmem_arbiter;

    localparam int AW       = 32;
    localparam int WAITW    = 4;
    localparam int WAIT_MAX = (1 << WAITW) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             c_req, c_gnt, c_rvalid;
    logic [31:0]      c_addr, c_wdata, c_rdata;
    logic [3:0]       c_we;
    logic             a_req, a_gnt, a_we, a_beat, a_rvalid;
    logic [31:0]      a_addr;
    logic [2:0]       a_len, a_beat_idx;
    logic [255:0]     a_wdata, a_rdata;
    logic [31:0]      daddr, dwdata, drdata;
    logic [3:0]       dwe;
    logic [255:0]     mm_dwdata, mm_drdata;
    logic             mm_dwe;
    logic [WAITW-1:0] cpu_wait_cnt;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .MAX_BEATS(8), .LINE_BYTES(32), .WAITW(WAITW)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_gnt(c_gnt), .c_addr(c_addr), .c_wdata(c_wdata), .c_we(c_we),
        .c_rdata(c_rdata), .c_rvalid(c_rvalid),
        .a_req(a_req), .a_gnt(a_gnt), .a_addr(a_addr), .a_len(a_len), .a_we(a_we),
        .a_wdata(a_wdata), .a_beat(a_beat), .a_beat_idx(a_beat_idx),
        .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata),
        .mm_dwdata(mm_dwdata), .mm_dwe(mm_dwe), .mm_drdata(mm_drdata),
        .cpu_wait_cnt(cpu_wait_cnt)
    );

    logic [7:0] mem [4096];
    logic [7:0] ref_mem [4096];

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int busy_until = -1;
    int m_wait = 0;
    int arv_count = 0;
    bit m_last_acc = 1'b1;
    bit post_reset = 1'b0;
    bit rst_req = 1'b0;
    logic [31:0] m_daddr = '0;

    bit           cp = 1'b0;
    logic [31:0]  cp_addr, cp_wdata;
    logic [3:0]   cp_we;
    bit           ap = 1'b0;
    logic [31:0]  ap_addr;
    logic [2:0]   ap_len;
    bit           ap_we;
    logic [255:0] ap_data [8];

    bit           e_set [32];
    logic [31:0]  e_daddr [32];
    logic [3:0]   e_dwe [32];
    logic [31:0]  e_cwdata [32];
    bit           e_mmdwe [32];
    bit           e_beat [32];
    logic [2:0]   e_idx [32];
    logic [255:0] e_wline [32];
    bit           e_crv [32];
    logic [31:0]  e_crdata [32];
    bit           e_arv [32];
    logic [255:0] e_ardata [32];

    function automatic logic [31:0] word_of(input bit use_ref, input logic [31:0] a);
        logic [31:0] v;
        int b;
        b = int'(a & 32'h0000_0FFC);
        for (int i = 0; i < 4; i++) v[i*8 +: 8] = use_ref ? ref_mem[b+i] : mem[b+i];
        return v;
    endfunction

    function automatic logic [255:0] line_of(input bit use_ref, input logic [31:0] a);
        logic [255:0] v;
        int b;
        b = int'(a & 32'h0000_0FE0);
        for (int i = 0; i < 32; i++) v[i*8 +: 8] = use_ref ? ref_mem[b+i] : mem[b+i];
        return v;
    endfunction

    task automatic write_word(input bit use_ref, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] we);
        int b;
        b = int'(a & 32'h0000_0FFC);
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                if (use_ref) ref_mem[b+i] = d[i*8 +: 8];
                else         mem[b+i]     = d[i*8 +: 8];
            end
        end
    endtask

    task automatic write_line(input bit use_ref, input logic [31:0] a, input logic [255:0] d);
        int b;
        b = int'(a & 32'h0000_0FE0);
        for (int i = 0; i < 32; i++) begin
            if (use_ref) ref_mem[b+i] = d[i*8 +: 8];
            else         mem[b+i]     = d[i*8 +: 8];
        end
    endtask

    task automatic clear_slot(input int s);
        e_set[s] = 0; e_daddr[s] = '0; e_dwe[s] = '0; e_cwdata[s] = '0;
        e_mmdwe[s] = 0; e_beat[s] = 0; e_idx[s] = '0; e_wline[s] = '0;
        e_crv[s] = 0; e_crdata[s] = '0; e_arv[s] = 0; e_ardata[s] = '0;
    endtask

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic cpu_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
        cp = 1'b1; cp_addr = a; cp_wdata = d; cp_we = we;
    endtask

    task automatic acc_issue(input logic [31:0] a, input logic [2:0] len, input bit we);
        ap = 1'b1; ap_addr = a; ap_len = len; ap_we = we;
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 8; j++) ap_data[k][j*32 +: 32] = $urandom();
    endtask

    // One clock cycle: drive pending requests, compare against the schedule, accept.
    task automatic applyStimulus();
        int s, t;
        bit cg, ag;
        logic [31:0] base;
        @(negedge clk);
        s = cyc % 32;
        reset = rst_req;
        c_req = cp; c_addr = cp_addr; c_wdata = cp_wdata; c_we = cp_we;
        a_req = ap; a_addr = ap_addr; a_len = ap_len; a_we = ap_we;
        if (e_mmdwe[s]) a_wdata = e_wline[s];
        else for (int j = 0; j < 8; j++) a_wdata[j*32 +: 32] = $urandom();
        #1;
        drdata    = word_of(0, daddr);
        mm_drdata = line_of(0, daddr);
        #1;
        if (rst_req) begin
            checkOutput("rst_c_gnt", c_gnt, 0);
            checkOutput("rst_a_gnt", a_gnt, 0);
            checkOutput("rst_dwe", dwe, 0);
            checkOutput("rst_mm_dwe", mm_dwe, 0);
        end else begin
            if (post_reset) begin
                checkOutput("post_rst_c_rdata", c_rdata, 0);
                checkOutput("post_rst_a_rdata", a_rdata, 0);
                checkOutput("post_rst_beat_idx", a_beat_idx, 0);
            end
            if (e_set[s]) m_daddr = e_daddr[s];
            checkOutput("daddr", daddr, m_daddr);
            checkOutput("dwe", dwe, e_dwe[s]);
            checkOutput("mm_dwe", mm_dwe, e_mmdwe[s]);
            checkOutput("a_beat", a_beat, e_beat[s]);
            if (e_beat[s]) checkOutput("a_beat_idx", a_beat_idx, e_idx[s]);
            if (e_dwe[s] != 0) checkOutput("dwdata", dwdata, e_cwdata[s]);
            checkOutput("c_rvalid", c_rvalid, e_crv[s]);
            if (e_crv[s]) checkOutput("c_rdata", c_rdata, e_crdata[s]);
            checkOutput("a_rvalid", a_rvalid, e_arv[s]);
            if (e_arv[s]) checkOutput("a_rdata", a_rdata, e_ardata[s]);
            checkOutput("cpu_wait_cnt", cpu_wait_cnt, m_wait);
            if (e_dwe[s] != 0) write_word(1, e_daddr[s], e_cwdata[s], e_dwe[s]);
            if (e_mmdwe[s]) write_line(1, e_daddr[s], e_wline[s]);

            cg = (cyc >= busy_until) && cp && (!ap || m_last_acc);
            ag = (cyc >= busy_until) && ap && !cg;
            checkOutput("c_gnt", c_gnt, cg);
            checkOutput("a_gnt", a_gnt, ag);
            if (cp && !cg && m_wait < WAIT_MAX) m_wait++;
            if (cg) begin
                t = (cyc + 1) % 32;
                e_set[t] = 1; e_daddr[t] = cp_addr; e_dwe[t] = cp_we; e_cwdata[t] = cp_wdata;
                if (cp_we == 0) begin
                    t = (cyc + 2) % 32;
                    e_crv[t] = 1; e_crdata[t] = word_of(1, cp_addr);
                end
                busy_until = cyc + 1; m_last_acc = 0; cp = 0;
            end else if (ag) begin
                base = ap_addr & ~32'd31;
                for (int k = 0; k <= int'(ap_len); k++) begin
                    t = (cyc + 1 + k) % 32;
                    e_set[t] = 1; e_daddr[t] = base + 32'(32 * k); e_beat[t] = 1;
                    e_idx[t] = 3'(k); e_mmdwe[t] = ap_we; e_wline[t] = ap_data[k];
                    if (!ap_we) begin
                        t = (cyc + 2 + k) % 32;
                        e_arv[t] = 1; e_ardata[t] = line_of(1, base + 32'(32 * k));
                    end
                end
                busy_until = cyc + 1 + int'(ap_len); m_last_acc = 1; ap = 0;
            end
        end
        if (a_rvalid && !rst_req) arv_count++;
        if (dwe != 0) write_word(0, daddr, dwdata, dwe);
        if (mm_dwe) write_line(0, daddr, mm_dwdata);
        clear_slot(s);
        if (rst_req) begin
            for (int i = 0; i < 32; i++) clear_slot(i);
            m_daddr = '0; m_last_acc = 1; busy_until = -1; m_wait = 0;
            cp = 0; ap = 0; post_reset = 1;
        end else begin
            post_reset = 0;
        end
        cyc++;
    endtask

    task automatic run_until_idle(input int limit);
        int n = 0;
        while ((cp || ap || cyc <= busy_until + 2) && n < limit) begin
            applyStimulus();
            n++;
        end
        checkOutput("idle_timeout", n < limit, 1);
    endtask

    task automatic wait_acc_accept(input int limit);
        int n = 0;
        while (ap && n < limit) begin
            applyStimulus();
            n++;
        end
        checkOutput("accept_timeout", n < limit, 1);
    endtask

    task automatic pulse_reset();
        rst_req = 1; applyStimulus(); rst_req = 0;
    endtask

    initial begin
        logic [255:0] saved1, old2;
        int arv0;
        reset = 1; c_req = 0; a_req = 0; c_addr = '0; c_wdata = '0; c_we = '0;
        a_addr = '0; a_len = '0; a_we = 0; a_wdata = '0; drdata = '0; mm_drdata = '0;
        cp_addr = '0; cp_wdata = '0; cp_we = '0; ap_addr = '0; ap_len = '0; ap_we = 0;
        for (int i = 0; i < 32; i++) clear_slot(i);
        for (int i = 0; i < 4096; i++) begin
            mem[i] = 8'($urandom());
            ref_mem[i] = mem[i];
        end
        pulse_reset();
        pulse_reset();

        cpu_issue(32'h40, 32'hDEADBEEF, 4'hF);
        run_until_idle(20);
        checkOutput("t1_mem_word", word_of(0, 32'h40), 32'hDEADBEEF);
        cpu_issue(32'h40, 32'h0, 4'h0);
        run_until_idle(20);

        acc_issue(32'h100, 3'd3, 1'b1);
        run_until_idle(30);

        pulse_reset();
        cpu_issue(32'h80, 32'h1234_5678, 4'h3);
        acc_issue(32'h180, 3'd1, 1'b0);
        run_until_idle(30);
        cpu_issue(32'h84, 32'h0, 4'h0);
        acc_issue(32'h1A0, 3'd0, 1'b1);
        run_until_idle(30);

        pulse_reset();
        arv0 = arv_count;
        acc_issue(32'h200, 3'd7, 1'b0);
        wait_acc_accept(10);
        cpu_issue(32'h300, 32'h0, 4'h0);
        run_until_idle(40);
        checkOutput("t4_wait_cnt", cpu_wait_cnt, 7);
        checkOutput("t4_rvalid_pulses", arv_count - arv0, 8);

        acc_issue(32'h400, 3'd3, 1'b1);
        saved1 = ap_data[1];
        old2 = line_of(1, 32'h440);
        wait_acc_accept(10);
        applyStimulus();
        applyStimulus();
        pulse_reset();
        acc_issue(32'h400, 3'd3, 1'b0);
        run_until_idle(30);
        checkOutput("t5_beat1_kept", line_of(0, 32'h420), saved1);
        checkOutput("t5_beat2_dropped", line_of(0, 32'h440), old2);

        acc_issue(32'h10F, 3'd0, 1'b0);
        run_until_idle(20);
        acc_issue(32'hFFFF_FFE0, 3'd1, 1'b0);
        run_until_idle(20);
        for (int r = 0; r < 3; r++) begin
            acc_issue(32'h500, 3'd7, 1'b0);
            wait_acc_accept(10);
            cpu_issue(32'h504, 32'h0, 4'h0);
            run_until_idle(40);
        end
        checkOutput("t6_wait_saturated", cpu_wait_cnt, WAIT_MAX);

        for (int i = 0; i < 800; i++) begin
            if (!cp && $urandom_range(2) == 0)
                cpu_issue(32'($urandom_range(4095)), $urandom(),
                          ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom()));
            if (!ap && $urandom_range(5) == 0)
                acc_issue($urandom(), 3'($urandom_range(7)), 1'($urandom_range(1)));
            rst_req = ($urandom_range(199) == 0);
            applyStimulus();
            rst_req = 0;
        end
        run_until_idle(60);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
